operand_fetch: RTL and testbench

Operand-fetch stage that sits between the decoder and execute and acts as the read/write-address initiator for the 2R1W register file. The register file has a 1-cycle registered read, so this stage:

- holds read addresses stable across stalls,
- tracks in-flight destination registers with a 32-bit scoreboard,
- stalls on RAW/WAW hazards,
- bypasses same-cycle writeback data that the register file cannot yet return.

Decoder and execute connect through valid/ready handshakes.

---
 rtl/operand_fetch_pkg.sv | 22 ++
 rtl/operand_fetch_scoreboard.sv | 63 ++++++
 rtl/operand_fetch.sv | 187 ++++++++++++++++++
 tb/tb_operand_fetch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
//   Shared CPU definitions used by the operand-fetch stage: datapath and
//   register-address widths, the hardwired-zero register index and the
//   payload carried through the stage alongside the operands.
package operand_fetch_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int PC_W   = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Instruction fields that travel with an instruction through the stage.
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic [PC_W-1:0]   pc;
  } of_payload_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// opfetch_scoreboard
//   Busy-bit scoreboard for in-flight destination registers.
//   Ports:
//     clk, rst          clock / asynchronous active-high reset
//     set_en, set_idx   mark a register busy (instruction accepted)
//     clr_en, clr_idx   mark a register free (writeback)
//     q_rs1, q_rs2      source indices to test for hazards
//     q_rd, q_rd_en     destination index to test, only when q_rd_en
//     hazard            any queried register is busy and not freed this cycle
//   A set and a clear of the same index in one cycle leave the bit set:
//   the clear belongs to the older writer, the set to the newer one.
module opfetch_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  input  logic [REG_AW-1:0] q_rd,
  input  logic              q_rd_en,
  output logic              hazard
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            hz_rs1;
  logic            hz_rs2;
  logic            hz_rd;

  // A register being written back this cycle no longer blocks: its value
  // is available on the bypass path at the same edge.
  assign hz_rs1 = (q_rs1 != '0) && busy_q[q_rs1] && !(clr_en && (clr_idx == q_rs1));
  assign hz_rs2 = (q_rs2 != '0) && busy_q[q_rs2] && !(clr_en && (clr_idx == q_rs2));
  assign hz_rd  = q_rd_en && (q_rd != '0) && busy_q[q_rd] && !(clr_en && (clr_idx == q_rd));
  assign hazard = hz_rs1 || hz_rs2 || hz_rd;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_idx] = 1'b0;
    end
    // Applied after the clear so that a simultaneous set wins.
    if (set_en) begin
      busy_d[set_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
//   Operand-fetch stage between decoder and execute. Drives the read
//   addresses of a 2R1W register file with 1-cycle registered read, tracks
//   in-flight destinations, stalls on RAW/WAW hazards and bypasses
//   writeback data arriving in the same cycle as an accept.
//   Ports:
//     clk, rst                     clock / asynchronous active-high reset
//     in_valid, in_ready           decoder handshake
//     in_rs1, in_rs2, in_rd,
//     in_rd_we, in_pc              decoded instruction fields
//     rf_rs1, rf_rs2               register-file read addresses
//     rf_rs1_data, rf_rs2_data     register-file data (address + 1 cycle)
//     wb_valid, wb_rd, wb_data     writeback (also writes the register file)
//     out_valid, out_ready         execute handshake
//     out_rs1_data, out_rs2_data   resolved operands
//     out_rd, out_rd_we, out_pc    passthrough fields
//   Pipeline: A (address stage, waiting for rf data) -> O (output register).
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [31:0]       in_pc,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic [31:0]       out_pc
);

  import operand_fetch_pkg::*;

  // A stage
  logic              a_valid_q, a_valid_d;
  of_payload_t       a_pl_q, a_pl_d;
  logic              a_byp1_q, a_byp1_d;
  logic              a_byp2_q, a_byp2_d;
  logic [DATA_W-1:0] a_byp1_data_q, a_byp1_data_d;
  logic [DATA_W-1:0] a_byp2_data_q, a_byp2_data_d;

  // O stage
  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_rs1_data_q, o_rs1_data_d;
  logic [DATA_W-1:0] o_rs2_data_q, o_rs2_data_d;
  logic [REG_AW-1:0] o_rd_q, o_rd_d;
  logic              o_rd_we_q, o_rd_we_d;
  logic [31:0]       o_pc_q, o_pc_d;

  logic hazard;
  logic a_move;
  logic accept;
  logic in_byp1;
  logic in_byp2;
  logic sb_set;

  assign a_move   = a_valid_q && (!o_valid_q || out_ready);
  assign in_ready = (!a_valid_q || a_move) && !hazard;
  assign accept   = in_valid && in_ready;

  // Writeback landing at the accept edge: the register file returns the
  // pre-write value for this read, so the new value is captured here.
  assign in_byp1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != REG_ZERO);
  assign in_byp2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != REG_ZERO);

  assign sb_set = accept && in_rd_we && (in_rd != REG_ZERO);

  // While A is stuck, keep presenting its sources so the registered read
  // data still belongs to A when it finally moves.
  assign rf_rs1 = (a_valid_q && !a_move) ? a_pl_q.rs1 : in_rs1;
  assign rf_rs2 = (a_valid_q && !a_move) ? a_pl_q.rs2 : in_rs2;

  opfetch_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (sb_set),
    .set_idx (in_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .q_rs1   (in_rs1),
    .q_rs2   (in_rs2),
    .q_rd    (in_rd),
    .q_rd_en (in_rd_we),
    .hazard  (hazard)
  );

  always_comb begin
    a_valid_d     = a_valid_q;
    a_pl_d        = a_pl_q;
    a_byp1_d      = a_byp1_q;
    a_byp2_d      = a_byp2_q;
    a_byp1_data_d = a_byp1_data_q;
    a_byp2_data_d = a_byp2_data_q;
    if (accept) begin
      a_valid_d     = 1'b1;
      a_pl_d.rs1    = in_rs1;
      a_pl_d.rs2    = in_rs2;
      a_pl_d.rd     = in_rd;
      a_pl_d.rd_we  = in_rd_we;
      a_pl_d.pc     = in_pc;
      a_byp1_d      = in_byp1;
      a_byp2_d      = in_byp2;
      a_byp1_data_d = wb_data;
      a_byp2_data_d = wb_data;
    end else if (a_move) begin
      a_valid_d = 1'b0;
    end
  end

  // Sources were free when accepted, so the captured operands cannot be
  // invalidated by a later writeback; no update path is needed in O.
  always_comb begin
    o_valid_d    = o_valid_q;
    o_rs1_data_d = o_rs1_data_q;
    o_rs2_data_d = o_rs2_data_q;
    o_rd_d       = o_rd_q;
    o_rd_we_d    = o_rd_we_q;
    o_pc_d       = o_pc_q;
    if (a_move) begin
      o_valid_d    = 1'b1;
      o_rs1_data_d = (a_pl_q.rs1 == REG_ZERO) ? '0 :
                     a_byp1_q ? a_byp1_data_q : rf_rs1_data;
      o_rs2_data_d = (a_pl_q.rs2 == REG_ZERO) ? '0 :
                     a_byp2_q ? a_byp2_data_q : rf_rs2_data;
      o_rd_d       = a_pl_q.rd;
      o_rd_we_d    = a_pl_q.rd_we;
      o_pc_d       = a_pl_q.pc;
    end else if (out_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q     <= 1'b0;
      a_pl_q        <= '0;
      a_byp1_q      <= 1'b0;
      a_byp2_q      <= 1'b0;
      a_byp1_data_q <= '0;
      a_byp2_data_q <= '0;
      o_valid_q     <= 1'b0;
      o_rs1_data_q  <= '0;
      o_rs2_data_q  <= '0;
      o_rd_q        <= '0;
      o_rd_we_q     <= 1'b0;
      o_pc_q        <= '0;
    end else begin
      a_valid_q     <= a_valid_d;
      a_pl_q        <= a_pl_d;
      a_byp1_q      <= a_byp1_d;
      a_byp2_q      <= a_byp2_d;
      a_byp1_data_q <= a_byp1_data_d;
      a_byp2_data_q <= a_byp2_data_d;
      o_valid_q     <= o_valid_d;
      o_rs1_data_q  <= o_rs1_data_d;
      o_rs2_data_q  <= o_rs2_data_d;
      o_rd_q        <= o_rd_d;
      o_rd_we_q     <= o_rd_we_d;
      o_pc_q        <= o_pc_d;
    end
  end

  assign out_valid    = o_valid_q;
  assign out_rs1_data = o_rs1_data_q;
  assign out_rs2_data = o_rs2_data_q;
  assign out_rd       = o_rd_q;
  assign out_rd_we    = o_rd_we_q;
  assign out_pc       = o_pc_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
  logic              in_rd_we;
  logic [31:0]       in_pc;
  logic [REG_AW-1:0] rf_rs1, rf_rs2;
  logic [DATA_W-1:0] rf_rs1_data, rf_rs2_data;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rs1_data, out_rs2_data;
  logic [REG_AW-1:0] out_rd;
  logic              out_rd_we;
  logic [31:0]       out_pc;

  operand_fetch #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_pc(in_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural register contents as seen by software; x0 holds a
  // poison value in the register file so that forcing to zero is visible.
  logic [31:0] arch [NREG];
  bit          arch_loaded = 0;
  bit          pending [NREG];

  // Register-file environment: registered read returns the value before
  // a same-edge write.
  logic [31:0] rf_mem [NREG];
  always @(posedge clk) begin
    rf_rs1_data <= rf_mem[rf_rs1];
    rf_rs2_data <= rf_mem[rf_rs2];
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= arch[i];
    end else if (wb_valid) begin
      rf_mem[wb_rd] <= wb_data;
    end
  end

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] pc;
    int          t;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   nout = 0;
  bit   exp_ready;
  bit   exp_ovalid;

  function automatic bit reg_blocks(input logic [4:0] r);
    return (r != 0) && pending[r] && !(wb_valid && wb_rd == r);
  endfunction

  // Reference model and monitor, evaluated mid-cycle where every input
  // and every DUT output is stable for the coming rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!arch_loaded) begin
      for (int i = 0; i < NREG; i++) arch[i] = $urandom;
      arch[0] = 32'hFFFF_FFFF;
      arch[3] = 32'd5;
      arch[4] = 32'd7;
      arch_loaded = 1;
    end
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < NREG; i++) pending[i] = 0;
    end else begin
      exp_ready = !(reg_blocks(in_rs1) || reg_blocks(in_rs2) || (in_rd_we && reg_blocks(in_rd)))
                  && (exp_q.size() < 2 || out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      exp_ovalid = (exp_q.size() > 0) && (exp_q[0].t <= cyc - 2);
      chk("out_valid", 32'(out_valid), 32'(exp_ovalid));

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got pc 0x%08h required no output", out_pc);
        end else begin
          e = exp_q.pop_front();
          nout++;
          chk("out_rs1_data", out_rs1_data, e.d1);
          chk("out_rs2_data", out_rs2_data, e.d2);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_rd_we", 32'(out_rd_we), 32'(e.rd_we));
          chk("out_pc", out_pc, e.pc);
          $display("out #%0d pc=%08h op1=%08h op2=%08h rd=%0d we=%0d",
                   nout, out_pc, out_rs1_data, out_rs2_data, out_rd, out_rd_we);
        end
      end

      // Operands are the register values after this edge's writeback.
      if (wb_valid && wb_rd != 0) arch[wb_rd] = wb_data;
      if (in_valid && in_ready) begin
        e.d1    = (in_rs1 == 0) ? 32'd0 : arch[in_rs1];
        e.d2    = (in_rs2 == 0) ? 32'd0 : arch[in_rs2];
        e.rd    = in_rd;
        e.rd_we = in_rd_we;
        e.pc    = in_pc;
        e.t     = cyc;
        exp_q.push_back(e);
      end
      if (wb_valid) pending[wb_rd] = 0;
      if (in_valid && in_ready && in_rd_we && in_rd != 0) pending[in_rd] = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) step();
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [31:0] pc);
    bit done;
    done     = 0;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_rd_we = we;
    in_pc    = pc;
    in_valid = 1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      step();
    end
    in_valid = 0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: pc 0x%08h got no accept required accept within 40 cycles", pc);
    end
  endtask

  int cand[$];

  task automatic drive_random_wb(input int one_in);
    cand.delete();
    for (int r = 1; r < NREG; r++) if (pending[r]) cand.push_back(r);
    if (cand.size() > 0 && ($urandom % one_in) == 0) begin
      wb_valid = 1;
      wb_rd    = REG_AW'(cand[$urandom % cand.size()]);
      wb_data  = $urandom;
    end else begin
      wb_valid = 0;
    end
  endtask

  initial begin
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_pc = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    rst = 1;
    repeat (3) step();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_rs1_data", out_rs1_data, 32'd0);
    chk("reset_out_rs2_data", out_rs2_data, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 0;
    step();

    // Basic read: x3=5, x4=7.
    issue(5'd3, 5'd4, 5'd1, 1'b0, 32'h100);
    idle(3);

    // Zero register: operands forced to 0; rd=0 writes are not tracked.
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h110);
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'h114);
    idle(3);

    // RAW stall, then accept with same-cycle writeback bypass.
    issue(5'd1, 5'd2, 5'd5, 1'b1, 32'h200);
    in_rs1 = 5; in_rs2 = 0; in_rd = 6; in_rd_we = 0; in_pc = 32'h204; in_valid = 1;
    @(negedge clk);
    chk("raw_stall", 32'(in_ready), 32'd0);
    step();
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("raw_bypass_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 0; wb_valid = 0;
    idle(3);

    // Backpressure: O and A full, rf addresses held on A's sources.
    out_ready = 0;
    issue(5'd3, 5'd4, 5'd8, 1'b0, 32'h300);
    issue(5'd4, 5'd3, 5'd9, 1'b0, 32'h304);
    in_rs1 = 10; in_rs2 = 11; in_rd = 12; in_rd_we = 0; in_pc = 32'h308; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_rf_rs1_hold", 32'(rf_rs1), 32'd4);
      chk("bp_rf_rs2_hold", 32'(rf_rs2), 32'd3);
      step();
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_accept", 32'(in_ready), 32'd1);
    step();
    idle(4);

    // WAW stall, set-wins on the releasing edge, second writeback clears.
    issue(5'd1, 5'd2, 5'd7, 1'b1, 32'h400);
    in_rs1 = 1; in_rs2 = 2; in_rd = 7; in_rd_we = 1; in_pc = 32'h404; in_valid = 1;
    @(negedge clk);
    chk("waw_stall", 32'(in_ready), 32'd0);
    step();
    wb_valid = 1; wb_rd = 7; wb_data = 32'h1111_0007;
    @(negedge clk);
    chk("waw_accept", 32'(in_ready), 32'd1);
    step();
    wb_valid = 0; in_rs1 = 7; in_rd = 0; in_rd_we = 0; in_pc = 32'h408;
    @(negedge clk);
    chk("set_wins_still_busy", 32'(in_ready), 32'd0);
    step();
    wb_valid = 1; wb_rd = 7; wb_data = 32'h2222_0007;
    @(negedge clk);
    chk("second_wb_accept", 32'(in_ready), 32'd1);
    step();
    wb_valid = 0;
    idle(2);
    issue(5'd7, 5'd7, 5'd0, 1'b0, 32'h40C);
    idle(3);

    // Asynchronous reset while stalled with O full.
    out_ready = 0;
    issue(5'd1, 5'd2, 5'd5, 1'b1, 32'h500);
    issue(5'd3, 5'd4, 5'd0, 1'b0, 32'h504);
    in_rs1 = 5; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_pc = 32'h508; in_valid = 1;
    @(negedge clk);
    chk("pre_rst_stall", 32'(in_ready), 32'd0);
    #2;
    rst = 1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 0;
    @(negedge clk);
    step();
    rst = 0;
    out_ready = 1;
    in_valid = 1;
    @(negedge clk);
    chk("post_rst_no_stall", 32'(in_ready), 32'd1);
    step();
    in_valid = 0;
    idle(3);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_rs1    = 5'($urandom_range(0, 7));
      in_rs2    = 5'($urandom_range(0, 7));
      in_rd     = 5'($urandom_range(0, 7));
      in_rd_we  = 1'($urandom % 2);
      in_pc     = $urandom;
      out_ready = ($urandom % 4) != 0;
      drive_random_wb(3);
      step();
    end

    // Drain: retire all writebacks and outputs.
    in_valid  = 0;
    out_ready = 1;
    for (int c = 0; c < 200; c++) begin
      drive_random_wb(1);
      step();
    end
    wb_valid = 0;
    idle(4);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
